// File: rtl/gearbox_arb_if.sv
// Source/gearbox bundle for the round-robin gearbox scheduler.
// The source side drives the requests. The arbiter drives ready and the gearbox strobe.
interface gearbox_arb_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]    req_valid;
    logic [24*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]    req_last;
    logic [NUM_CH-1:0]    req_ready;
    logic [23:0]          gb_data_in;
    logic                 gb_data_in_last;
    logic                 gb_data_en;
    logic [CH_W-1:0]      grant_ch;
    logic                 busy;
    logic                 trunc_err;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, gb_data_in, gb_data_in_last, gb_data_en, grant_ch, busy, trunc_err
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, gb_data_in, gb_data_in_last, gb_data_en, grant_ch, busy, trunc_err
    );
endinterface

// File: rtl/gearbox_arb.sv
// Packet-granular round-robin scheduler in front of a 24-to-32 gearbox.
// It inserts an idle gap after each packet so the gearbox can flush, and it truncates packets at MAX_BEATS.
module gearbox_arb #(
    parameter int NUM_CH     = 4,
    parameter int GAP_CYCLES = 3,
    parameter int MAX_BEATS  = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    gearbox_arb_if.slave  bus
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t             state_reg, state_next;
    logic [CH_W-1:0]    ptr_reg, ptr_next;
    logic [CH_W-1:0]    grant_reg, grant_next;
    logic [BEAT_W-1:0]  beat_reg, beat_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [23:0]        data_reg, data_next;
    logic               last_reg, last_next;
    logic               en_reg, en_next;
    logic               trunc_reg, trunc_next;

    logic [23:0]        src_data [NUM_CH];
    logic               found;
    logic [CH_W-1:0]    winner;
    logic [CH_W:0]      probe;
    logic               hit_max;
    logic               end_pkt;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign src_data[gi]      = bus.req_data[24*gi +: 24];
        assign bus.req_ready[gi] = (state_reg == XFER) && (grant_reg == CH_W'(gi));
    end

    // First valid source strictly after the pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = ptr_reg;
        probe  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            probe = {1'b0, ptr_reg} + (CH_W+1)'(k);
            if (probe >= (CH_W+1)'(NUM_CH))
                probe = probe - (CH_W+1)'(NUM_CH);
            if (!found && bus.req_valid[probe[CH_W-1:0]]) begin
                found  = 1'b1;
                winner = probe[CH_W-1:0];
            end
        end
    end

    assign hit_max = (beat_reg == BEAT_W'(MAX_BEATS - 1));
    assign end_pkt = bus.req_last[grant_reg] | hit_max;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        beat_next  = beat_reg;
        gap_next   = gap_reg;
        data_next  = data_reg;
        last_next  = 1'b0;
        en_next    = 1'b0;
        trunc_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && found) begin
                    grant_next = winner;
                    ptr_next   = winner;
                    beat_next  = '0;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (bus.req_valid[grant_reg]) begin
                    en_next    = 1'b1;
                    data_next  = src_data[grant_reg];
                    last_next  = end_pkt;
                    // A packet whose real last lands exactly on MAX_BEATS is complete, not truncated.
                    trunc_next = hit_max & ~bus.req_last[grant_reg];
                    beat_next  = beat_reg + 1'b1;
                    if (end_pkt) begin
                        gap_next   = GAP_W'(GAP_CYCLES);
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                gap_next = gap_reg - 1'b1;
                if (gap_reg <= GAP_W'(1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= CH_W'(NUM_CH - 1);
            grant_reg <= '0;
            beat_reg  <= '0;
            gap_reg   <= '0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
            en_reg    <= 1'b0;
            trunc_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            beat_reg  <= beat_next;
            gap_reg   <= gap_next;
            data_reg  <= data_next;
            last_reg  <= last_next;
            en_reg    <= en_next;
            trunc_reg <= trunc_next;
        end
    end

    assign bus.gb_data_in      = data_reg;
    assign bus.gb_data_in_last = last_reg;
    assign bus.gb_data_en      = en_reg;
    assign bus.grant_ch        = grant_reg;
    assign bus.busy            = (state_reg != IDLE);
    assign bus.trunc_err       = trunc_reg;
endmodule

// File: tb/tb_gearbox_arb.sv
// Randomized bench for gearbox_arb. A behavioural scheduler model predicts every output on every cycle.
// The stimulus covers random bubbles, contention, enable toggles, resets and over-length packets.
module tb_gearbox_arb;
    localparam int NUM_CH     = 4;
    localparam int GAP_CYCLES = 3;
    localparam int MAX_BEATS  = 8;
    localparam int N_CYCLES   = 3000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;

    gearbox_arb_if #(.NUM_CH(NUM_CH)) bus ();

    gearbox_arb #(
        .NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_strobe = 0;
    int n_trunc  = 0;

    // Each source holds a queue of pending beats. Bit 24 is the last flag.
    logic [24:0] src_q [NUM_CH][$];
    int          seq   [NUM_CH];

    // Model state: phase 0 = waiting, 1 = streaming, 2 = cooling down.
    int          m_phase, m_who, m_ptr, m_beats, m_gap;
    logic [23:0] e_data;
    logic        e_en, e_last, e_trunc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic refill(input int ch);
        int len;
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            src_q[ch].push_back({(i == len - 1), 4'(ch), 20'(seq[ch])});
            seq[ch]++;
        end
    endtask

    task automatic model_step();
        int acc, best, bestd, d;
        logic lst;
        acc = -1;
        e_en = 1'b0;
        e_last = 1'b0;
        e_trunc = 1'b0;
        if (!reset) begin
            m_phase = 0; m_who = 0; m_ptr = NUM_CH - 1;
            m_beats = 0; m_gap = 0; e_data = '0;
        end else begin
            case (m_phase)
                0: if (enable && bus.req_valid != '0) begin
                    best = 0;
                    bestd = NUM_CH;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        d = (ch - m_ptr - 1 + 2 * NUM_CH) % NUM_CH;
                        if (bus.req_valid[ch] && d < bestd) begin
                            bestd = d;
                            best = ch;
                        end
                    end
                    m_who = best; m_ptr = best; m_beats = 0; m_phase = 1;
                end
                1: if (bus.req_valid[m_who]) begin
                    acc = m_who;
                    m_beats++;
                    lst = bus.req_last[m_who];
                    e_en = 1'b1;
                    e_data = bus.req_data[24*m_who +: 24];
                    e_last = lst || (m_beats == MAX_BEATS);
                    e_trunc = !lst && (m_beats == MAX_BEATS);
                    if (e_last) begin
                        m_phase = 2;
                        m_gap = GAP_CYCLES;
                    end
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_phase = 0;
                end
            endcase
        end
        if (acc >= 0) void'(src_q[acc].pop_front());
    endtask

    task automatic drive_inputs();
        logic [24:0] head;
        reset = ($urandom_range(0, 249) != 0);
        if ($urandom_range(0, 29) == 0) enable = ~enable;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (src_q[ch].size() == 0) refill(ch);
            head = src_q[ch][0];
            bus.req_valid[ch] = ($urandom_range(0, 3) != 0);
            bus.req_data[24*ch +: 24] = head[23:0];
            bus.req_last[ch] = head[24];
        end
    endtask

    task automatic compare_outputs();
        logic [NUM_CH-1:0] exp_ready;
        exp_ready = '0;
        if (m_phase == 1) exp_ready[m_who] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("gb_data_en", 32'(bus.gb_data_en), 32'(e_en));
        check("gb_data_in", 32'(bus.gb_data_in), 32'(e_data));
        check("gb_data_in_last", 32'(bus.gb_data_in_last), 32'(e_last));
        check("trunc_err", 32'(bus.trunc_err), 32'(e_trunc));
        check("grant_ch", 32'(bus.grant_ch), 32'(m_who));
        check("busy", 32'(bus.busy), 32'(m_phase != 0));
        if (bus.gb_data_en) begin
            n_strobe++;
            $display("beat cyc=%0d ch=%0d data=%06h last=%0b trunc=%0b",
                     cyc, bus.grant_ch, bus.gb_data_in, bus.gb_data_in_last, bus.trunc_err);
        end
        if (bus.trunc_err) n_trunc++;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) seq[ch] = 0;
        @(negedge clk);
        reset = 1'b0;
        model_step();
        @(negedge clk);
        cyc++;
        compare_outputs();
        reset = 1'b1;
        enable = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            refill(ch);
            bus.req_valid[ch] = 1'b1;
            bus.req_data[24*ch +: 24] = src_q[ch][0][23:0];
            bus.req_last[ch] = src_q[ch][0][24];
        end
        model_step();
        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk);
            cyc++;
            compare_outputs();
            drive_inputs();
            model_step();
        end
        check("strobes_seen", 32'(n_strobe > 200), 32'd1);
        check("truncations_seen", 32'(n_trunc > 0), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gearbox_arb.md
Name: gearbox_arb

Overview:
- Packet-granular round-robin scheduler that shares one 24-to-32 gearbox among NUM_CH 24-bit packet sources.
- Grants one source at a time and forwards its beats as a registered data/last/enable strobe to the gearbox input.
- After each packet's last beat it enforces an idle gap so the gearbox can flush its residual word and re-align its phase.
- Watchdog-truncates over-length packets.

Parameters:
- NUM_CH, 4: number of requesting sources (2..8).
- GAP_CYCLES, 3: idle cycles after a last beat before the next grant (>=1).
- MAX_BEATS, 256: maximum beats per packet; the beat that reaches this count is forced to last.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  permits new grants; sampled only in IDLE.
- req_valid  in  NUM_CH  per-source beat valid.
- req_data  in  24*NUM_CH  per-source beat; source i at bits [24*i+23:24*i].
- req_last  in  NUM_CH  per-source end-of-packet, qualified by valid.
- req_ready  out  NUM_CH  per-source accept (combinational from state).
- gb_data_in  out  24  beat to gearbox.
- gb_data_in_last  out  1  last-beat flag to gearbox, one-cycle pulse.
- gb_data_en  out  1  beat strobe to gearbox.
- grant_ch  out  clog2(NUM_CH)  currently/last granted source.
- busy  out  1  high in XFER or GAP.
- trunc_err  out  1  one-cycle pulse when a packet is truncated at MAX_BEATS.

Behaviour:
- Reset (reset==0 at posedge), including mid-packet: FSM to IDLE; all outputs 0; req_ready 0; beat and gap counters 0; round-robin pointer set to NUM_CH-1 so source 0 has top priority first.
- States:
  - IDLE: if enable and any req_valid, select the first valid source searching upward from pointer+1 with wrap. Register grant_ch, update pointer to the winner, clear the beat counter, go to XFER. Otherwise stay.
  - XFER: req_ready[grant_ch]=1, all others 0. On req_valid&req_ready, next cycle gb_data_en=1 and gb_data_in=source data. gb_data_in_last=req_last, OR forced 1 when beat count reaches MAX_BEATS (trunc_err=1 same cycle). Beat counter increments per accepted beat. Last (real or forced) beat -> load gap counter with GAP_CYCLES, go to GAP. A cycle with no valid gives gb_data_en=0 (bubble), stays in XFER.
  - GAP: req_ready all 0; gb_data_en and gb_data_in_last 0. Gap counter decrements each cycle; at 1 -> IDLE.
- Latency: accepted beat appears on gb_* exactly 1 cycle later. gb_data_in holds its last value when gb_data_en=0. gb_data_in_last never high without gb_data_en.
- Minimum spacing: last beat strobe to next packet's first strobe = GAP_CYCLES + 2 cycles (GAP, IDLE arbitration, XFER accept).
- Truncation: beats remaining in the source after a forced last are treated as a new packet in a later grant.
- enable deasserted mid-packet does not abort; the packet and its gap complete, then the block holds in IDLE.
- req_last on a non-granted source is ignored. Single-beat packet (first beat last) is legal.
- Simultaneous valids resolved strictly by the round-robin pointer; no source is granted twice while another is waiting.

Test Plan:
- Single source 0, 4-beat packet 0x000001..0x000004, last on beat 4 -> gb_data_en high 4 consecutive cycles starting 1 cycle after first accept; gb_data_in_last high only with 0x000004; busy high through 3 gap cycles.
- All 4 sources valid continuously with 2-beat packets -> grant order 0,1,2,3,0; exactly GAP_CYCLES+1 cycles with gb_data_en=0 between a last strobe and the next packet's first strobe.
- MAX_BEATS=8, source 1 sends 10 beats with last on beat 10 -> gb_data_in_last and trunc_err pulse on beat 8; beats 9-10 emitted as a separate 2-beat packet with last on beat 10.
- Source 2 drops req_valid for 2 cycles mid-packet -> gb_data_en low for those 2 cycles; data order preserved; no spurious last.
- enable deasserted during source 3's packet -> packet and gap finish; no further grant until enable returns.
- reset asserted on beat 3 of a 6-beat packet -> next cycle all outputs 0, state IDLE; after release, source 0 is granted first.
